// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter slice.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Width of the burst counter; holds MAX_BURST values up to 15.
  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DBG
  } owner_t;

  // The requester opposite to o (NONE maps to CPU so a fresh tie favours the CPU).
  function automatic owner_t other_of(input owner_t o);
    return (o == OWN_CPU) ? OWN_DBG : OWN_CPU;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic with a bounded burst per owner.
// Grants are combinational; owner, last and burst_cnt advance at each posedge.
module rr_arb2
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic cpu_gnt,
  output logic dbg_gnt
);

  localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] ONE_CNT = BURST_W'(1);

  owner_t               owner_q, owner_d;
  owner_t               last_q, last_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  owner_t               gnt;

  // State register: reset leaves no owner and lets the CPU win the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= OWN_NONE;
      last_q      <= OWN_DBG;
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Grant decision: lone requester wins; on a tie the owner keeps it until its burst is spent.
  always_comb begin
    gnt = OWN_NONE;
    if (rst) begin
      if (cpu_req && !dbg_req) begin
        gnt = OWN_CPU;
      end else if (dbg_req && !cpu_req) begin
        gnt = OWN_DBG;
      end else if (cpu_req && dbg_req) begin
        if (owner_q == OWN_NONE) begin
          gnt = other_of(last_q);
        end else if (burst_cnt_q < MAX_CNT) begin
          gnt = owner_q;
        end else begin
          gnt = other_of(owner_q);
        end
      end
    end
  end

  // Next state: extend the burst on a repeat grant, restart it on a handover, clear on idle.
  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (gnt == OWN_NONE) begin
      owner_d     = OWN_NONE;
      burst_cnt_d = '0;
    end else begin
      last_d = gnt;
      if (gnt == owner_q) begin
        if (burst_cnt_q < MAX_CNT) begin
          burst_cnt_d = burst_cnt_q + ONE_CNT;
        end
      end else begin
        owner_d     = gnt;
        burst_cnt_d = ONE_CNT;
      end
    end
  end

  assign cpu_gnt = (gnt == OWN_CPU);
  assign dbg_gnt = (gnt == OWN_DBG);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the CPU data port and the debug/loader port.
// Accesses complete in the granted cycle; debug reads are returned one cycle later.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              dbg_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              dbg_rd;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;

  rr_arb2 #(
    .MAX_BURST (MAX_BURST)
  ) u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .cpu_gnt (cpu_gnt),
    .dbg_gnt (dbg_gnt)
  );

  assign cpu_ack   = cpu_gnt;
  assign dbg_ack   = dbg_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Memory bus mux: idle bus shows the CPU's fields; reset parks it at zero with writes off.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (!rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
    end
  end

  assign cpu_rdata = (cpu_gnt && !cpu_we) ? mem_rdata : '0;

  // Debug read capture: latch data on an acked read, otherwise hold it.
  always_comb begin
    dbg_rd       = dbg_gnt & ~dbg_we;
    dbg_rvalid_d = dbg_rd;
    dbg_rdata_d  = dbg_rd ? mem_rdata : dbg_rdata_q;
  end

  // Debug read-return registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int MB = 4;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dbg_req, dbg_we;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_ack, dbg_rvalid;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  // Physical memory driven by the DUT bus, and the model's own view of memory.
  logic [15:0] phys    [0:65535];
  logic [15:0] ref_mem [0:65535];

  // Model state: previous grant (0 none, 1 cpu, 2 dbg), run length, last holder.
  int          m_prev   = 0;
  int          m_streak = 0;
  int          m_last   = 2;
  logic        m_rvalid = 1'b0;
  logic [15:0] m_rdata  = 16'h0;
  logic        exp_cpu_ack = 1'b0;
  logic        exp_dbg_ack = 1'b0;

  dmem_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata),
    .dbg_ack    (dbg_ack),
    .dbg_rvalid (dbg_rvalid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = phys[mem_addr];

  always @(posedge clk) begin
    if (mem_we) phys[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model and comparison, evaluated mid-cycle when outputs are settled.
  always @(negedge clk) begin : cmp
    int          g;
    logic        e_we;
    logic [15:0] e_addr, e_wd, e_crd;
    g = 0;
    if (rst) begin
      if (cpu_req && !dbg_req)      g = 1;
      else if (dbg_req && !cpu_req) g = 2;
      else if (cpu_req && dbg_req)  g = (m_prev != 0 && m_streak < MB) ? m_prev : ((m_last == 1) ? 2 : 1);
    end
    exp_cpu_ack = (g == 1);
    exp_dbg_ack = (g == 2);
    e_we   = 1'b0;
    e_addr = rst ? cpu_addr : 16'h0;
    e_wd   = rst ? cpu_wdata : 16'h0;
    if (g == 1) begin
      e_we = cpu_we;
    end else if (g == 2) begin
      e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata;
    end
    e_crd = (g == 1 && !cpu_we) ? ref_mem[cpu_addr] : 16'h0;

    chk("cpu_ack",    cpu_ack,    exp_cpu_ack);
    chk("dbg_ack",    dbg_ack,    exp_dbg_ack);
    chk("cpu_stall",  cpu_stall,  cpu_req & ~exp_cpu_ack);
    chk("mem_we",     mem_we,     e_we);
    chk("mem_addr",   mem_addr,   e_addr);
    chk("mem_wdata",  mem_wdata,  e_wd);
    chk("cpu_rdata",  cpu_rdata,  e_crd);
    chk("dbg_rvalid", dbg_rvalid, m_rvalid);
    chk("dbg_rdata",  dbg_rdata,  m_rdata);

    if (!rst) begin
      m_prev = 0; m_streak = 0; m_last = 2;
      m_rvalid = 1'b0; m_rdata = 16'h0;
    end else begin
      m_rvalid = (g == 2 && !dbg_we);
      if (m_rvalid) m_rdata = ref_mem[dbg_addr];
      if (g != 0) begin
        if (e_we) ref_mem[e_addr] = e_wd;
        m_streak = (g == m_prev) ? ((m_streak < MB) ? m_streak + 1 : MB) : 1;
        m_last   = g;
        m_prev   = g;
      end else begin
        m_prev = 0; m_streak = 0;
      end
    end
  end

  task automatic set_in(input logic r,
                        input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                        input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd);
    rst = r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic log_txn(input string tag);
    $display("%-10s rst=%0b cpu_req=%0b cpu_ack=%0b dbg_req=%0b dbg_ack=%0b mem_we=%0b addr=%04h wdata=%04h crd=%04h drd=%04h rv=%0b",
             tag, rst, cpu_req, cpu_ack, dbg_req, dbg_ack, mem_we, mem_addr, mem_wdata, cpu_rdata, dbg_rdata, dbg_rvalid);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      phys[a]    = 16'h0;
      ref_mem[a] = 16'h0;
    end

    // Reset held two cycles with both ports requesting.
    set_in(1'b0, 1'b1, 1'b1, 16'h0010, 16'hAAAA, 1'b1, 1'b1, 16'h0004, 16'h5555);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) adv();
      settle();
      log_txn("reset");
      chk("rst_cpu_ack", cpu_ack, 1'b0);
      chk("rst_dbg_ack", dbg_ack, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_cpu_stall", cpu_stall, 1'b1);
      chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    end

    // Continuous contention: CPU x4, DBG x4, CPU x4.
    for (int i = 0; i < 12; i++) begin
      adv();
      set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0004, 16'h0);
      settle();
      log_txn("contend");
      chk("contend_cpu_ack", cpu_ack, (i < 4 || i >= 8));
      chk("contend_dbg_ack", dbg_ack, (i >= 4 && i < 8));
      chk("contend_stall", cpu_stall, (i >= 4 && i < 8));
      chk("model_contend", exp_cpu_ack, (i < 4 || i >= 8));
    end

    // Idle: no grant, bus shows CPU fields.
    adv();
    set_in(1'b1, 1'b0, 1'b1, 16'h0077, 16'h0066, 1'b0, 1'b0, 16'h0004, 16'h0);
    settle();
    log_txn("idle");
    chk("idle_mem_we", mem_we, 1'b0);
    chk("idle_mem_addr", mem_addr, 16'h0077);
    chk("idle_acks", {cpu_ack, dbg_ack}, 2'b00);

    // CPU alone: write then read back with zero latency.
    adv();
    set_in(1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0);
    settle();
    log_txn("cpu_wr");
    chk("cpuwr_ack", cpu_ack, 1'b1);
    chk("cpuwr_mem_we", mem_we, 1'b1);
    chk("cpuwr_mem_addr", mem_addr, 16'h0010);
    chk("cpuwr_stall", cpu_stall, 1'b0);
    adv();
    set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    settle();
    log_txn("cpu_rd");
    chk("cpurd_rdata", cpu_rdata, 16'hBEEF);

    // Debug alone: write, read, registered return.
    adv();
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0004, 16'h1234);
    settle();
    log_txn("dbg_wr");
    chk("dbgwr_ack", dbg_ack, 1'b1);
    adv();
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0004, 16'h0);
    settle();
    log_txn("dbg_rd");
    chk("dbgrd_ack", dbg_ack, 1'b1);
    chk("dbgrd_rvalid_early", dbg_rvalid, 1'b0);
    adv();
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    settle();
    log_txn("dbg_ret");
    chk("dbgret_rvalid", dbg_rvalid, 1'b1);
    chk("dbgret_rdata", dbg_rdata, 16'h1234);
    adv();
    settle();
    log_txn("dbg_after");
    chk("dbgafter_rvalid", dbg_rvalid, 1'b0);
    chk("dbgafter_rdata_hold", dbg_rdata, 16'h1234);

    // Early release: CPU x2, CPU drops, DBG granted same cycle and runs a fresh burst of 4.
    for (int i = 0; i < 7; i++) begin
      adv();
      set_in(1'b1, (i != 2), 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0004, 16'h0);
      settle();
      log_txn("early");
      chk("early_cpu_ack", cpu_ack, (i < 2 || i == 6));
      chk("early_dbg_ack", dbg_ack, (i >= 2 && i < 6));
      chk("model_early", exp_dbg_ack, (i >= 2 && i < 6));
    end

    // Reset during the third CPU write of a burst.
    adv();
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    settle();
    adv();
    set_in(1'b1, 1'b1, 1'b1, 16'h0020, 16'h1111, 1'b0, 1'b0, 16'h0, 16'h0);
    settle();
    log_txn("burst_wr");
    adv();
    set_in(1'b1, 1'b1, 1'b1, 16'h0021, 16'h2222, 1'b0, 1'b0, 16'h0, 16'h0);
    settle();
    log_txn("burst_wr");
    adv();
    set_in(1'b0, 1'b1, 1'b1, 16'h0022, 16'h3333, 1'b0, 1'b0, 16'h0, 16'h0);
    settle();
    log_txn("burst_rst");
    chk("midrst_mem_we", mem_we, 1'b0);
    chk("midrst_cpu_ack", cpu_ack, 1'b0);
    chk("midrst_stall", cpu_stall, 1'b1);
    adv();
    set_in(1'b1, 1'b1, 1'b1, 16'h0022, 16'h3333, 1'b1, 1'b0, 16'h0004, 16'h0);
    settle();
    log_txn("post_rst");
    chk("midrst_mem_unchanged", phys[16'h0022], 16'h0000);
    chk("midrst_wr0_landed", phys[16'h0020], 16'h1111);
    chk("postrst_cpu_ack", cpu_ack, 1'b1);
    chk("model_postrst", exp_cpu_ack, 1'b1);

    // Randomized traffic; fields are held until ack unless the request is dropped.
    for (int n = 0; n < 3000; n++) begin
      logic prev_rst;
      adv();
      prev_rst = rst;
      if (!cpu_req || exp_cpu_ack || !prev_rst) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(0, 31));
        cpu_wdata = 16'($urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        cpu_req = 1'b0;
      end
      if (!dbg_req || exp_dbg_ack || !prev_rst) begin
        dbg_req   = ($urandom_range(0, 2) != 0);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 16'($urandom_range(0, 31));
        dbg_wdata = 16'($urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        dbg_req = 1'b0;
      end
      rst = ($urandom_range(0, 149) != 0);
      settle();
    end

    adv();
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
